pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the general successor to the fixed ID/EX latch. It carries a packed control word, N data words and M register-destination fields from one stage to the next. It uses a valid/ready handshake, a 2-entry skid buffer for full throughput with a registered ready, and a synchronous flush that inserts a bubble. One instance serves IF/ID, ID/EX, EX/MEM or MEM/WB by parameter choice.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_skid_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - default widths, control-field layout and bubble constant for pipe_stage_reg
package pipe_pkg;

   localparam int P_CTRL_W = 8;
   localparam int P_DATA_W = 32;
   localparam int P_DEST_W = 5;

   // Control word layout, MSB first: WB[7:6] | M[5:3] | EXE[2:0]
   localparam int CTRL_WB_LSB  = 6;
   localparam int CTRL_WB_W    = 2;
   localparam int CTRL_M_LSB   = 3;
   localparam int CTRL_M_W     = 3;
   localparam int CTRL_EXE_LSB = 0;
   localparam int CTRL_EXE_W   = 3;

   localparam logic [P_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one valid+payload register with load and clear (clear wins)
module pipe_skid_slot
   import pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Clear only drops the valid bit; the payload is left as a don't-care.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with 2-entry skid and flush
// Optional perf counters (stall_cnt, flush_cnt) under PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = P_CTRL_W,
   parameter int DATA_W   = P_DATA_W,
   parameter int NUM_DATA = 4,
   parameter int DEST_W   = P_DEST_W,
   parameter int NUM_DEST = 2
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   parameter int CNT_W    = 16
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL_W-1:0]          ctrl_in,
   input  logic [NUM_DATA*DATA_W-1:0] data_in,
   input  logic [NUM_DEST*DEST_W-1:0] dest_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          ctrl_out,
   output logic [NUM_DATA*DATA_W-1:0] data_out,
   output logic [NUM_DEST*DEST_W-1:0] dest_out
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           flush_cnt
`endif
);

   localparam int DD_W  = NUM_DATA*DATA_W + NUM_DEST*DEST_W;
   localparam int PAY_W = CTRL_W + DD_W;

   logic             w_main_valid, w_skid_valid;
   logic             w_accept, w_release;
   logic             w_main_from_skid, w_main_load, w_main_clear;
   logic             w_skid_load, w_skid_clear;
   logic [PAY_W-1:0] w_in_pay, w_skid_pay, w_main_src;
   logic [DD_W-1:0]  w_main_dd;
   logic [CTRL_W-1:0] r_ctrl_out;

   assign w_in_pay   = {ctrl_in, data_in, dest_in};
   assign in_ready   = !w_skid_valid;
   assign w_accept   = in_valid && !w_skid_valid;
   assign w_release  = w_main_valid && out_ready;
   assign w_main_src = w_skid_valid ? w_skid_pay : w_in_pay;

   // A held skid entry always refills main first; in_ready is low then, so no input competes.
   assign w_main_from_skid = w_release && w_skid_valid;
   assign w_main_load  = !flush && (w_main_from_skid || (w_accept && (!w_main_valid || w_release)));
   assign w_main_clear = flush || (w_release && !w_main_load);
   assign w_skid_load  = !flush && w_accept && w_main_valid && !w_release;
   assign w_skid_clear = flush || w_main_from_skid;

   pipe_skid_slot #(.W(DD_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_data  (w_main_src[DD_W-1:0]),
      .o_valid (w_main_valid),
      .o_data  (w_main_dd)
   );

   pipe_skid_slot #(.W(PAY_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  (w_in_pay),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_pay)
   );

   // Control lives outside the main slot so it can drop to the bubble whenever main empties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl_out <= CTRL_W'(CTRL_BUBBLE);
      end else if (w_main_clear) begin
         r_ctrl_out <= CTRL_W'(CTRL_BUBBLE);
      end else if (w_main_load) begin
         r_ctrl_out <= w_main_src[PAY_W-1 -: CTRL_W];
      end
   end

   assign out_valid           = w_main_valid;
   assign ctrl_out            = r_ctrl_out;
   assign {data_out, dest_out} = w_main_dd;

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_main_valid && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (vector table, directed, random vs FIFO model)
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int CW = 8;
   localparam int DW = 32;
   localparam int ND = 4;
   localparam int RW = 5;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [CW-1:0]    ctrl_in, ctrl_out;
   logic [ND*DW-1:0] data_in, data_out;
   logic [NR*RW-1:0] dest_in, dest_out;
`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [3:0]       stall_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [CW-1:0]    ctrl;
      logic [ND*DW-1:0] data;
      logic [NR*RW-1:0] dest;
   } ent_t;

   // The stage behaves as a 2-deep FIFO whose head is what the outputs show.
   ent_t q[$];

   typedef struct {
      bit          iv;
      bit          ordy;
      bit          fl;
      logic [7:0]  ctrl;
      logic [31:0] d0;
      bit          e_ov;
      bit          e_ir;
      logic [7:0]  e_ctrl;
      logic [31:0] e_d0;
   } vec_t;

   vec_t tbl[14];

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .CTRL_W   (CW),
      .DATA_W   (DW),
      .NUM_DATA (ND),
      .DEST_W   (RW),
      .NUM_DEST (NR)
`ifdef PIPE_STAGE_PERF_CNT_EN
      ,
      .CNT_W    (4)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ctrl_in   (ctrl_in),
      .data_in   (data_in),
      .dest_in   (dest_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ctrl_out  (ctrl_out),
      .data_out  (data_out),
      .dest_out  (dest_out)
`ifdef PIPE_STAGE_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input bit v, input logic [CW-1:0] c, input logic [31:0] w0);
      in_valid = v;
      ctrl_in  = c;
      data_in  = {$urandom, $urandom, $urandom, w0};
      dest_in  = NR*RW'($urandom);
   endtask

   task automatic tick();
      ent_t e;
      bit   push, pop;
      if (flush) begin
         q.delete();
      end else begin
         push   = in_valid && (q.size() < 2);
         pop    = (q.size() > 0) && out_ready;
         e.ctrl = ctrl_in;
         e.data = data_in;
         e.dest = dest_in;
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
      chk({tag, ".in_ready"}, 128'(in_ready), 128'(q.size() < 2));
      if (q.size() > 0) begin
         chk({tag, ".ctrl_out"}, 128'(ctrl_out), 128'(q[0].ctrl));
         chk({tag, ".data_out"}, 128'(data_out), 128'(q[0].data));
         chk({tag, ".dest_out"}, 128'(dest_out), 128'(q[0].dest));
      end else begin
         chk({tag, ".ctrl_bubble"}, 128'(ctrl_out), 128'(CTRL_BUBBLE));
      end
   endtask

   initial begin
      tbl[0]  = '{1, 0, 0, 8'h11, 32'hA,  1, 1, 8'h11, 32'hA};
      tbl[1]  = '{1, 0, 0, 8'h22, 32'hB,  1, 0, 8'h11, 32'hA};
      tbl[2]  = '{1, 1, 0, 8'h2C, 32'hC,  1, 1, 8'h22, 32'hB};
      tbl[3]  = '{0, 1, 0, 8'h00, 32'h0,  0, 1, 8'h00, 32'h0};
      tbl[4]  = '{1, 0, 0, 8'h33, 32'hA2, 1, 1, 8'h33, 32'hA2};
      tbl[5]  = '{1, 0, 0, 8'h44, 32'hB2, 1, 0, 8'h33, 32'hA2};
      tbl[6]  = '{1, 0, 1, 8'h55, 32'hC2, 0, 1, 8'h00, 32'h0};
      tbl[7]  = '{0, 1, 0, 8'h00, 32'h0,  0, 1, 8'h00, 32'h0};
      tbl[8]  = '{0, 1, 0, 8'hFF, 32'h0,  0, 1, 8'h00, 32'h0};
      tbl[9]  = '{0, 1, 0, 8'hFF, 32'h0,  0, 1, 8'h00, 32'h0};
      tbl[10] = '{0, 1, 0, 8'hFF, 32'h0,  0, 1, 8'h00, 32'h0};
      tbl[11] = '{1, 0, 1, 8'h66, 32'hD,  0, 1, 8'h00, 32'h0};
      tbl[12] = '{1, 1, 0, 8'h77, 32'hE,  1, 1, 8'h77, 32'hE};
      tbl[13] = '{0, 1, 0, 8'h00, 32'h0,  0, 1, 8'h00, 32'h0};

      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      set_in(1'b0, '0, '0);
      #2 rst = 1'b0;
      #1;
      chk("reset.out_valid", 128'(out_valid), 128'(0));
      chk("reset.in_ready", 128'(in_ready), 128'(1));
      chk("reset.ctrl_out", 128'(ctrl_out), 128'(0));
      chk("reset.data_out", 128'(data_out), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Streaming at full rate
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, CW'($urandom), 32'h1000 + 32'(i));
         tick();
         chk($sformatf("stream%0d.out_valid", i), 128'(out_valid), 128'(1));
         chk($sformatf("stream%0d.in_ready", i), 128'(in_ready), 128'(1));
         chk($sformatf("stream%0d.word0", i), 128'(data_out[31:0]), 128'(32'h1000 + 32'(i)));
         check_model($sformatf("stream%0d", i));
      end
      set_in(1'b0, '0, '0);
      tick();
      check_model("drain");

      // Backpressure, flush with full skid, bubble control
      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].iv, tbl[i].ctrl, tbl[i].d0);
         out_ready = tbl[i].ordy;
         flush     = tbl[i].fl;
         tick();
         chk($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
         chk($sformatf("vec%0d.in_ready", i), 128'(in_ready), 128'(tbl[i].e_ir));
         chk($sformatf("vec%0d.ctrl_out", i), 128'(ctrl_out), 128'(tbl[i].e_ctrl));
         if (tbl[i].e_ov)
            chk($sformatf("vec%0d.word0", i), 128'(data_out[31:0]), 128'(tbl[i].e_d0));
      end
      flush = 1'b0;

      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3) != 0, CW'($urandom), $urandom);
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 15) == 0;
         tick();
         check_model($sformatf("rand%0d", i));
      end
      flush = 1'b0;

      // Async reset between edges with both slots full
      out_ready = 1'b0;
      set_in(1'b1, 8'hC3, 32'h5A5A5A5A);
      tick();
      set_in(1'b1, 8'h3C, 32'hA5A5A5A5);
      tick();
      chk("prereset.in_ready", 128'(in_ready), 128'(0));
      #2 rst = 1'b0;
      #1;
      chk("midreset.out_valid", 128'(out_valid), 128'(0));
      chk("midreset.in_ready", 128'(in_ready), 128'(1));
      chk("midreset.ctrl_out", 128'(ctrl_out), 128'(0));
      chk("midreset.data_out", 128'(data_out), 128'(0));
      chk("midreset.dest_out", 128'(dest_out), 128'(0));
      q.delete();
      set_in(1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check_model("postreset");

`ifdef PIPE_STAGE_PERF_CNT_EN
      chk("perf.stall_init", 128'(stall_cnt), 128'(0));
      chk("perf.flush_init", 128'(flush_cnt), 128'(0));
      out_ready = 1'b0;
      set_in(1'b1, 8'h81, 32'h1234);
      for (int i = 0; i < 5; i++) tick();
      chk("perf.stall_4", 128'(stall_cnt), 128'(4));
      for (int i = 0; i < 15; i++) tick();
      chk("perf.stall_sat", 128'(stall_cnt), 128'(4'hF));
      for (int i = 0; i < 2; i++) begin
         flush = 1'b1;
         tick();
         flush = 1'b0;
         tick();
      end
      chk("perf.flush_2", 128'(flush_cnt), 128'(2));
      chk("perf.stall_hold", 128'(stall_cnt), 128'(4'hF));
      check_model("perf_end");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
